fifo_uart: RTL
==============

# fifo_uart

Memory-mapped UART for the PicoSoC peripheral space. It is the parametrised successor of the single-byte UART: independent TX/RX FIFOs of configurable depth, a status register with sticky error flags, and a level interrupt that can drive `irq[4]`. It attaches to the PicoRV32 native bus as one slave with a 4-word register window.

## Interface
- `TX_DEPTH`, 16: TX FIFO entries; power of two, ≥2.
- `RX_DEPTH`, 16: RX FIFO entries; power of two, ≥2.
- `DIV_RESET`, 32'd104: reset value of the DIV register.
- `clk` in 1: single clock, all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: request, held until `mem_ready`.
- `mem_ready` out 1: one-cycle acknowledge.
- `mem_addr` in 4: byte offset; bits [3:2] select the register.
- `mem_wstrb` in 4: byte write strobes; 0 means read.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: read data, valid while `mem_ready`=1.
- `ser_tx` out 1: serial output, idle high.
- `ser_rx` in 1: serial input, asynchronous.
- `irq` out 1: level interrupt.

## Operation
- Register map:
  - 0x0 DIV: read/write with byte strobes.
  - 0x4 DATA: write pushes `wdata[7:0]` to TX (needs `wstrb[0]`); read pops RX.
  - 0x8 STATUS: read; write-1-to-clear on bits [6:4] with `wstrb[0]`.
  - 0xC IE: bits [2:0], read/write.
- STATUS bits:
  - [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full.
  - [4] rx_ovr, [5] tx_ovf, [6] frame_err (all sticky).
  - [7] tx_busy.
  - [15:8] rx_count, zero-extended.
  - All other bits read 0.
- Bit period is max(DIV,2) clocks. DIV is latched at each frame start, so a write mid-frame takes effect on the next frame.
- Frame format: 8N1, LSB first.
- TX engine:
  - States IDLE → START → DATA(8) → STOP → IDLE.
  - Leaves IDLE when the FIFO is non-empty, popping the FIFO on the same cycle.
  - Back-to-back frames have no idle gap.
- RX engine:
  - `ser_rx` passes through a 2-FF synchroniser.
  - States IDLE → START → DATA → STOP.
  - A falling edge in IDLE starts the frame. The start bit is sampled at half-period; if it reads high, return to IDLE without error.
  - Data and stop bits are sampled at mid-bit.
  - Stop bit = 0: set frame_err, discard the byte.
  - Good byte with RX full: discard it, set rx_ovr.
- DATA write with TX full: byte dropped, tx_ovf set. A push on the same cycle the engine pops a full FIFO is accepted.
- DATA read with RX empty: returns 32'hFFFF_FFFF, no pop. Otherwise returns {24'h0, byte} and pops once per handshake.
- Writes to DATA ignore `wdata[31:8]`. Reads from any register have no side effects except DATA.

## Timing
- `mem_ready` is registered and rises the cycle after `mem_valid` is seen with `mem_ready`=0. It lasts exactly one cycle. Side effects (push, pop, W1C, DIV/IE update) occur on that same edge.
- STATUS reflects FIFO state as of the cycle before `mem_ready`.
- Write-to-`ser_tx` start-bit latency with TX idle: 2 clocks after the `mem_ready` edge.
- RX byte becomes readable 1 clock after the stop-bit sample.
- Reset values:
  - `ser_tx`=1, `mem_ready`=0, `mem_rdata`=0, `irq`=0.
  - Both FIFOs empty, sticky flags 0, IE=0, DIV=`DIV_RESET`, both FSMs IDLE.
- Reset asserted mid-frame aborts immediately; `ser_tx` returns high asynchronously.
- Simultaneous W1C and hardware set of the same sticky bit: the set wins.

## Configuration
- `FIFO_UART_IRQ_EN` defined:
  - IE register implemented.
  - `irq` = (IE[0] & !rx_empty) | (IE[1] & tx_empty) | (IE[2] & (rx_ovr|tx_ovf|frame_err)), registered, 1-cycle lag.
- Not defined:
  - IE reads 0 and writes are ignored.
  - `irq` is tied 0.
  - No interrupt logic is synthesised.

## Structure
- Package `fifo_uart_pkg` holds:
  - register offset constants;
  - STATUS bit index constants;
  - TX and RX state enums;
  - the 0xFFFF_FFFF empty-read constant.
- Sub-module `fifo_uart_fifo`: synchronous FIFO (parameter DEPTH, 8-bit data, push/pop/full/empty/count, async active-low reset). It is instantiated once for TX and once for RX.

## Test plan
- Reset, then read all registers → DIV=104, STATUS=0x0006, IE=0, `ser_tx`=1, `irq`=0.
- DIV=4, write DATA=0x55 → `ser_tx` start edge 2 clocks after ready, 10 bits of 4 clocks each: 0,1,0,1,0,1,0,1,0,1; tx_busy is 1 throughout.
- Write 17 bytes back-to-back with DIV=100, depth 16 → the first is popped into the engine, so none are dropped; an 18th write before the next pop sets tx_ovf. The W1C write 0x20 to STATUS clears it.
- Drive RX frame 0xA3 at DIV=8 → rx_count=1; DATA read returns 0x0000_00A3, then the next read returns 0xFFFF_FFFF.
- Send 17 RX frames without reading → rx_full, rx_ovr set, the first 16 bytes are intact; a frame with stop bit 0 sets frame_err and is not stored.
- With `FIFO_UART_IRQ_EN`, IE=1, receive one byte → `irq` rises; read DATA → `irq` falls 1 clock later. Assert `resetn` mid-TX-frame → `ser_tx`=1 immediately, FIFOs empty.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: register map, STATUS bit positions, engine state types and
// shared helpers for the fifo_uart peripheral.
package fifo_uart_pkg;

  // Register select values (mem_addr[3:2])
  localparam logic [1:0] REG_DIV    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_IE     = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_FRAME_ERR = 6;
  localparam int ST_TX_BUSY   = 7;

  // Value returned by a DATA read while the RX FIFO is empty
  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bit period in clocks; divisors below 2 are clamped to 2
  function automatic logic [31:0] bit_period(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

endpackage

// File: rtl/fifo_uart_fifo.sv
// fifo_uart_fifo: byte-wide synchronous FIFO with first-word fall-through
// read data. A push into a full FIFO is accepted only if a pop happens on
// the same cycle.
module fifo_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_uart.sv
// fifo_uart: memory-mapped 8N1 UART with TX/RX FIFOs on the PicoRV32 native
// bus. Define FIFO_UART_IRQ_EN to build the IE register and level interrupt;
// otherwise IE reads 0 and irq is tied low.
//
// TX states          | meaning
//   TX_IDLE          | line high, waiting for a byte in the TX FIFO
//   TX_START         | driving start bit
//   TX_DATA          | driving 8 data bits, LSB first
//   TX_STOP          | driving stop bit; chains straight into the next frame
// RX states          | meaning
//   RX_IDLE          | waiting for a falling edge on the synchronised input
//   RX_START         | waiting half a bit to confirm the start bit
//   RX_DATA          | sampling 8 data bits at mid-bit
//   RX_STOP          | sampling stop bit, then store / flag the byte
module fifo_uart #(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [31:0] DIV_RESET = 32'd104
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        ser_tx,
  input  logic        ser_rx,
  output logic        irq
);
  import fifo_uart_pkg::*;

  logic        req, wr, rd;
  logic [1:0]  reg_sel;
  logic [31:0] div, status, ie_word, rdata_nxt;
  logic        rx_ovr, tx_ovf, frame_err;
  logic        rx_ovr_set, tx_ovf_set, frame_err_set;
  logic [2:0]  w1c;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_dout, rx_dout;
  logic [$clog2(TX_DEPTH):0] tx_count_unused;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic        unused_addr;

  assign req     = mem_valid && !mem_ready;
  assign wr      = req && (mem_wstrb != 4'h0);
  assign rd      = req && (mem_wstrb == 4'h0);
  assign reg_sel = mem_addr[3:2];
  assign unused_addr = ^mem_addr[1:0];

  assign tx_push    = wr && (reg_sel == REG_DATA) && mem_wstrb[0];
  assign tx_ovf_set = tx_push && tx_full && !tx_pop;
  assign rx_pop     = rd && (reg_sel == REG_DATA);
  assign w1c        = (wr && (reg_sel == REG_STATUS) && mem_wstrb[0]) ? mem_wdata[6:4] : 3'b000;

  fifo_uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop), .wdata(mem_wdata[7:0]),
    .rdata(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count_unused)
  );

  // ---------------- TX engine ----------------
  tx_state_t   tx_state, tx_state_nxt;
  logic [31:0] tx_cnt, tx_cnt_nxt, tx_period, tx_period_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
  logic [2:0]  tx_bit, tx_bit_nxt;
  logic        tx_busy_q, tx_busy;

  // TX next-state: down-counter per bit, reload divisor at each frame start
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_cnt_nxt    = tx_cnt;
    tx_period_nxt = tx_period;
    tx_shift_nxt  = tx_shift;
    tx_bit_nxt    = tx_bit;
    tx_pop        = 1'b0;
    unique case (tx_state)
      TX_IDLE, TX_STOP: begin
        if (tx_state == TX_STOP && tx_cnt != '0) begin
          tx_cnt_nxt = tx_cnt - 1'b1;
        end else if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_shift_nxt  = tx_dout;
          tx_period_nxt = bit_period(div);
          tx_cnt_nxt    = bit_period(div) - 32'd1;
          tx_state_nxt  = TX_START;
        end else begin
          tx_state_nxt = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = tx_period - 32'd1;
          tx_bit_nxt   = 3'd0;
          tx_state_nxt = TX_DATA;
        end else tx_cnt_nxt = tx_cnt - 1'b1;
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = tx_period - 32'd1;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          tx_bit_nxt   = tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
        end else tx_cnt_nxt = tx_cnt - 1'b1;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX state register; ser_tx is registered from the current state (one-clock lag)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_period <= 32'd2;
      tx_shift  <= '0;
      tx_bit    <= '0;
      tx_busy_q <= 1'b0;
      ser_tx    <= 1'b1;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_period <= tx_period_nxt;
      tx_shift  <= tx_shift_nxt;
      tx_bit    <= tx_bit_nxt;
      tx_busy_q <= (tx_state != TX_IDLE);
      ser_tx    <= (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
    end
  end

  // busy_q covers the last stop-bit clock that ser_tx still drives after the FSM idles
  assign tx_busy = (tx_state != TX_IDLE) || tx_busy_q;

  // ---------------- RX engine ----------------
  rx_state_t   rx_state, rx_state_nxt;
  logic [31:0] rx_cnt, rx_cnt_nxt, rx_period, rx_period_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;
  logic        rx_s1, rx_s2, rx_s3;

  fifo_uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
    .rdata(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // RX next-state: edge detect, half-bit start check, mid-bit sampling
  always_comb begin
    rx_state_nxt  = rx_state;
    rx_cnt_nxt    = rx_cnt;
    rx_period_nxt = rx_period;
    rx_shift_nxt  = rx_shift;
    rx_bit_nxt    = rx_bit;
    rx_push       = 1'b0;
    rx_ovr_set    = 1'b0;
    frame_err_set = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_s3 && !rx_s2) begin
          rx_period_nxt = bit_period(div);
          rx_cnt_nxt    = (bit_period(div) >> 1) - 32'd1;
          rx_state_nxt  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          rx_cnt_nxt   = rx_period - 32'd1;
          rx_bit_nxt   = 3'd0;
          rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt_nxt = rx_cnt - 1'b1;
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_nxt   = rx_period - 32'd1;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end else rx_cnt_nxt = rx_cnt - 1'b1;
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_nxt = RX_IDLE;
          if (!rx_s2)       frame_err_set = 1'b1;
          else if (rx_full) rx_ovr_set    = 1'b1;
          else              rx_push       = 1'b1;
        end else rx_cnt_nxt = rx_cnt - 1'b1;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX state register and input synchroniser (s3 holds the previous sample for edge detect)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_period <= 32'd2;
      rx_shift  <= '0;
      rx_bit    <= '0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
    end else begin
      rx_state  <= rx_state_nxt;
      rx_cnt    <= rx_cnt_nxt;
      rx_period <= rx_period_nxt;
      rx_shift  <= rx_shift_nxt;
      rx_bit    <= rx_bit_nxt;
      rx_s1     <= ser_rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
    end
  end

  // ---------------- Registers and bus ----------------
  // STATUS word assembly
  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_RX_OVR]    = rx_ovr;
    status[ST_TX_OVF]    = tx_ovf;
    status[ST_FRAME_ERR] = frame_err;
    status[ST_TX_BUSY]   = tx_busy;
    status[15:8]         = 8'(rx_count);
  end

`ifdef FIFO_UART_IRQ_EN
  logic [2:0] ie;
  logic       irq_q;
  assign ie_word = {29'b0, ie};
  assign irq     = irq_q;

  // IE register and registered interrupt level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ie    <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr && (reg_sel == REG_IE) && mem_wstrb[0]) ie <= mem_wdata[2:0];
      irq_q <= (ie[0] && !rx_empty) || (ie[1] && tx_empty) ||
               (ie[2] && (rx_ovr || tx_ovf || frame_err));
    end
  end
`else
  assign ie_word = '0;
  assign irq     = 1'b0;
`endif

  // Read data mux, sampled into mem_rdata on the handshake edge
  always_comb begin
    rdata_nxt = '0;
    case (reg_sel)
      REG_DIV:    rdata_nxt = div;
      REG_DATA:   rdata_nxt = rx_empty ? EMPTY_READ : {24'h0, rx_dout};
      REG_STATUS: rdata_nxt = status;
      default:    rdata_nxt = ie_word;
    endcase
  end

  // Bus handshake, DIV writes and sticky flags (hardware set beats W1C)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      div       <= DIV_RESET;
      rx_ovr    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_ready <= req;
      if (req) mem_rdata <= rd ? rdata_nxt : 32'h0;
      if (wr && (reg_sel == REG_DIV)) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) div[8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rx_ovr    <= (rx_ovr    && !w1c[0]) || rx_ovr_set;
      tx_ovf    <= (tx_ovf    && !w1c[1]) || tx_ovf_set;
      frame_err <= (frame_err && !w1c[2]) || frame_err_set;
    end
  end

endmodule
